// File: rtl/uart_receiver_if.sv
// ============================================================================
// Module   : uart_receiver_if
// Purpose  : Serial line in, received byte and status pulses out.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface uart_receiver_if;
    logic       serial_input;
    logic [7:0] data_out;
    logic       data_valid;
    logic       framing_error;
    logic       busy;

    modport slave (
        input  serial_input,
        output data_out,
        output data_valid,
        output framing_error,
        output busy
    );

    modport master (
        output serial_input,
        input  data_out,
        input  data_valid,
        input  framing_error,
        input  busy
    );
endinterface

`default_nettype wire

// File: rtl/uart_receiver.sv
// ============================================================================
// Module   : uart_receiver
// Purpose  : 8N1 UART receiver, LSB first, mid-bit sampling, framing check.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_receiver #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic           clock,
    input  logic           reset_n,
    uart_receiver_if.slave rx_bus
);

    localparam int                 c_CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_FULL_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_baud_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic [7:0]         r_data_out;
    logic               r_data_valid;
    logic               r_framing_error;
    logic               r_busy;

    logic               r_sync1;
    logic               r_rx_s;
    logic               r_rx_d;

    // Idle-high synchronizer plus one extra stage for falling-edge detection
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
            r_rx_d  <= 1'b1;
        end else begin
            r_sync1 <= rx_bus.serial_input;
            r_rx_s  <= r_sync1;
            r_rx_d  <= r_rx_s;
        end
    end

    // Latency: with edge 1 the first clock edge that sees serial_input low,
    // data_valid is high after edge 9*CLKS_PER_BIT + CLKS_PER_BIT/2 + 3.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= IDLE;
            r_baud_cnt      <= '0;
            r_bit_idx       <= 3'd0;
            r_shift         <= 8'h00;
            r_data_out      <= 8'h00;
            r_data_valid    <= 1'b0;
            r_framing_error <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            r_data_valid    <= 1'b0;
            r_framing_error <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_rx_d && !r_rx_s) begin
                        r_state    <= START;
                        r_busy     <= 1'b1;
                        r_baud_cnt <= '0;
                        r_bit_idx  <= 3'd0;
                    end
                end
                START: begin
                    if (r_baud_cnt == c_HALF_LAST) begin
                        r_baud_cnt <= '0;
                        r_bit_idx  <= 3'd0;
                        if (!r_rx_s) begin
                            r_state <= DATA;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_CNT_ONE;
                    end
                end
                DATA: begin
                    if (r_baud_cnt == c_FULL_LAST) begin
                        r_baud_cnt         <= '0;
                        r_shift[r_bit_idx] <= r_rx_s;
                        if (r_bit_idx == 3'd7) begin
                            r_state   <= STOP;
                            r_bit_idx <= 3'd0;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_CNT_ONE;
                    end
                end
                STOP: begin
                    if (r_baud_cnt == c_FULL_LAST) begin
                        r_state    <= IDLE;
                        r_busy     <= 1'b0;
                        r_baud_cnt <= '0;
                        r_bit_idx  <= 3'd0;
                        if (r_rx_s) begin
                            r_data_out   <= r_shift;
                            r_data_valid <= 1'b1;
                        end else begin
                            r_framing_error <= 1'b1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_bus.data_out      = r_data_out;
    assign rx_bus.data_valid    = r_data_valid;
    assign rx_bus.framing_error = r_framing_error;
    assign rx_bus.busy          = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_receiver.sv
// ============================================================================
// Module   : tb_uart_receiver
// Purpose  : Directed frames against uart_receiver with CLKS_PER_BIT = 16.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_receiver;

    localparam int c_CLKS   = 16;
    localparam int c_PERIOD = 10;
    localparam int c_BIT    = c_CLKS * c_PERIOD;

    logic clock;
    logic reset_n;
    logic serial_input;

    int n_vec;
    int n_miss;

    int cyc;
    int fall_cyc;
    int last_valid_cyc;
    int n_valid;
    int n_fe;
    int n_both;
    logic [7:0] cap [0:31];

    uart_receiver_if bus ();
    assign bus.serial_input = serial_input;

    uart_receiver #(
        .CLKS_PER_BIT(c_CLKS)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .rx_bus (bus)
    );

    initial clock = 1'b0;
    always #(c_PERIOD / 2) clock = ~clock;

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (bus.data_valid) begin
            if (n_valid < 32) cap[n_valid] = bus.data_out;
            n_valid++;
            last_valid_cyc = cyc;
        end
        if (bus.framing_error) n_fe++;
        if (bus.data_valid && bus.framing_error) n_both++;
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Leaves the line at the stop-bit level when it returns
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input int bit_t);
        serial_input = 1'b0;
        fall_cyc     = cyc;
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            serial_input = d[i];
            #(bit_t);
        end
        serial_input = stop_b;
        #(bit_t);
    endtask

    int v0;
    int f0;
    int nb;

    initial begin
        n_vec = 0; n_miss = 0; cyc = 0; fall_cyc = 0; last_valid_cyc = 0;
        n_valid = 0; n_fe = 0; n_both = 0;
        serial_input = 1'b1;
        reset_n      = 1'b0;
        #23;
        check_value("rst_data_out", {24'h0, bus.data_out}, 32'h00);
        check_value("rst_valid",    {31'h0, bus.data_valid}, 32'h0);
        check_value("rst_ferr",     {31'h0, bus.framing_error}, 32'h0);
        check_value("rst_busy",     {31'h0, bus.busy}, 32'h0);
        reset_n = 1'b1;
        #100;

        // 0xA5, good stop bit, with latency check
        v0 = n_valid; f0 = n_fe;
        @(negedge clock);
        send_frame(8'hA5, 1'b1, c_BIT);
        #200;
        check_value("a5_pulses",  n_valid - v0, 1);
        check_value("a5_data",    {24'h0, bus.data_out}, 32'hA5);
        check_value("a5_ferr",    n_fe - f0, 0);
        check_value("a5_busy",    {31'h0, bus.busy}, 32'h0);
        check_value("a5_latency", last_valid_cyc - fall_cyc, 9 * c_CLKS + c_CLKS / 2 + 3);

        // 0x00 then 0xFF back-to-back
        v0 = n_valid; f0 = n_fe;
        @(negedge clock);
        send_frame(8'h00, 1'b1, c_BIT);
        send_frame(8'hFF, 1'b1, c_BIT);
        #200;
        check_value("b2b_pulses", n_valid - v0, 2);
        check_value("b2b_first",  {24'h0, cap[v0]}, 32'h00);
        check_value("b2b_second", {24'h0, cap[v0 + 1]}, 32'hFF);
        check_value("b2b_ferr",   n_fe - f0, 0);

        // 4-cycle glitch from idle
        v0 = n_valid; f0 = n_fe; nb = 0;
        @(negedge clock);
        serial_input = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (i == 3) serial_input = 1'b1;
            if (bus.busy) nb++;
        end
        check_value("glitch_valid",    n_valid - v0, 0);
        check_value("glitch_ferr",     n_fe - f0, 0);
        check_value("glitch_busy_len", {31'h0, (nb >= 1 && nb <= 11)}, 32'h1);
        check_value("glitch_idle",     {31'h0, bus.busy}, 32'h0);

        // 0x3C with low stop bit, then 40 bit times of break
        v0 = n_valid; f0 = n_fe;
        @(negedge clock);
        send_frame(8'h3C, 1'b0, c_BIT);
        #(20 * c_BIT);
        check_value("brk_busy_mid", {31'h0, bus.busy}, 32'h0);
        #(20 * c_BIT);
        check_value("brk_ferr",  n_fe - f0, 1);
        check_value("brk_valid", n_valid - v0, 0);
        check_value("brk_data",  {24'h0, bus.data_out}, 32'hFF);
        serial_input = 1'b1;
        #(2 * c_BIT);
        v0 = n_valid;
        @(negedge clock);
        send_frame(8'h12, 1'b1, c_BIT);
        #200;
        check_value("after_brk_pulse", n_valid - v0, 1);
        check_value("after_brk_data",  {24'h0, bus.data_out}, 32'h12);

        // Reset during data bit 4 of 0x5A, release once the line is idle
        v0 = n_valid; f0 = n_fe;
        @(negedge clock);
        fork
            send_frame(8'h5A, 1'b1, c_BIT);
            begin
                #(5 * c_BIT + c_BIT / 2);
                reset_n = 1'b0;
                #2;
                check_value("mid_rst_busy", {31'h0, bus.busy}, 32'h0);
                check_value("mid_rst_data", {24'h0, bus.data_out}, 32'h00);
            end
        join
        #37;
        reset_n = 1'b1;
        #400;
        check_value("mid_rst_valid", n_valid - v0, 0);
        check_value("mid_rst_ferr",  n_fe - f0, 0);
        @(negedge clock);
        send_frame(8'h81, 1'b1, c_BIT);
        #200;
        check_value("post_rst_pulse", n_valid - v0, 1);
        check_value("post_rst_data",  {24'h0, bus.data_out}, 32'h81);

        // Bit-rate tolerance: 15.5 and 16.5 clocks per bit
        v0 = n_valid;
        @(negedge clock);
        #2;
        send_frame(8'h55, 1'b1, c_BIT - c_PERIOD / 2);
        #300;
        check_value("fast_data",  {24'h0, bus.data_out}, 32'h55);
        check_value("fast_pulse", n_valid - v0, 1);
        @(negedge clock);
        #2;
        send_frame(8'hAA, 1'b1, c_BIT + c_PERIOD / 2);
        #300;
        check_value("slow_data_aa", {24'h0, bus.data_out}, 32'hAA);
        @(negedge clock);
        #2;
        send_frame(8'h55, 1'b1, c_BIT + c_PERIOD / 2);
        #300;
        check_value("slow_data_55", {24'h0, bus.data_out}, 32'h55);
        check_value("slow_pulses",  n_valid - v0, 3);

        check_value("never_both", n_both, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
